// File: rtl/vector_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vector_mem_sequencer
// Purpose  : MEM-stage access sequencer. Turns one R-lane vector (or scalar)
//            load/store from the EX/MEM register into R (or 1) sequential
//            byte accesses on a single-port, byte-wide synchronous memory.
//            The pipeline is stalled until the access completes; the
//            assembled load vector is presented to MEM/WB on ReadDataM.
// Ports    : clk, reset (sync, active-low)
//            MemWriteM / MemtoRegM / VectorM / AddressM / WriteDataM - request
//            ReadDataM  - assembled load data (registered)
//            StallM     - pipeline freeze (combinational)
//            DoneM      - one-cycle completion pulse
//            mem_addr / mem_wdata / mem_we / mem_re - memory strobes (reg.)
//            mem_rdata  - memory read byte, valid one cycle after mem_re
// Revision : 1.0 - initial release
// ============================================================================
module vector_mem_sequencer #(
  parameter int I = 32,  // address width
  parameter int N = 8,   // lane width = memory data width
  parameter int R = 6    // number of vector lanes
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           MemWriteM,
  input  logic           MemtoRegM,
  input  logic           VectorM,
  input  logic [I-1:0]   AddressM,
  input  logic [R*N-1:0] WriteDataM,
  output logic [R*N-1:0] ReadDataM,
  output logic           StallM,
  output logic           DoneM,
  output logic [I-1:0]   mem_addr,
  output logic [N-1:0]   mem_wdata,
  output logic           mem_we,
  output logic           mem_re,
  input  logic [N-1:0]   mem_rdata
);

  // Lane counter must be able to hold the lane count R itself.
  localparam int KW = $clog2(R + 1);
  localparam logic [KW-1:0] c_LC_VECTOR = KW'(R);
  localparam logic [KW-1:0] c_LC_SCALAR = KW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 state_q;
  logic [KW-1:0]          k_q;        // lane currently on the memory strobes
  logic [KW-1:0]          lc_q;       // lanes in this access
  logic [I-1:0]           base_q;
  logic [R*N-1:0]         wdata_q;    // remaining store lanes, next lane in LSBs
  logic                   is_store_q;
  logic                   done_q;
  logic                   mem_we_q;
  logic                   mem_re_q;
  logic [I-1:0]           mem_addr_q;
  logic [N-1:0]           mem_wdata_q;
  logic [R-1:0][N-1:0]    rdata_q;

  logic                   req;
  logic                   last_lane;
  logic                   cap_en;
  logic [KW-1:0]          cap_lane;
  logic [KW-1:0]          k_d;
  logic [I-1:0]           addr_d;

  assign req       = MemWriteM | MemtoRegM;
  assign last_lane = (k_q == (lc_q - KW'(1)));
  assign k_d       = k_q + KW'(1);
  // Lane address wraps modulo 2^I by plain truncation of the sum.
  assign addr_d    = base_q + I'(k_d);

  // Read data lags the read strobe by one cycle: in BUSY lane k we capture
  // the byte requested for lane k-1; DRAIN captures the final lane.
  assign cap_en   = !is_store_q &&
                    (((state_q == S_BUSY) && (k_q != '0)) || (state_q == S_DRAIN));
  assign cap_lane = (state_q == S_DRAIN) ? (lc_q - KW'(1)) : (k_q - KW'(1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      lc_q        <= '0;
      base_q      <= '0;
      wdata_q     <= '0;
      is_store_q  <= 1'b0;
      done_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      done_q <= 1'b0;

      if (cap_en) begin
        for (int j = 0; j < R; j++) begin
          if (cap_lane == KW'(j)) rdata_q[j] <= mem_rdata;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (req) begin
            // Store has priority when both request bits are set.
            base_q     <= AddressM;
            is_store_q <= MemWriteM;
            lc_q       <= VectorM ? c_LC_VECTOR : c_LC_SCALAR;
            k_q        <= '0;
            state_q    <= S_BUSY;
            // Strobes are registered, so lane 0 is set up here and appears
            // on the memory port in the first BUSY cycle.
            mem_addr_q  <= AddressM;
            mem_wdata_q <= WriteDataM[N-1:0];
            wdata_q     <= WriteDataM >> N;
            mem_we_q    <= MemWriteM;
            mem_re_q    <= !MemWriteM;
            if (!MemWriteM) rdata_q <= '0;
          end
        end

        S_BUSY: begin
          if (last_lane) begin
            mem_we_q <= 1'b0;
            mem_re_q <= 1'b0;
            if (is_store_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_DRAIN;
            end
          end else begin
            k_q         <= k_d;
            mem_addr_q  <= addr_d;
            mem_wdata_q <= wdata_q[N-1:0];
            wdata_q     <= wdata_q >> N;
          end
        end

        S_DRAIN: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end

        S_DONE: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Stall is held while a request waits in IDLE and for the whole access;
  // it drops in DONE so the pipeline advances on that edge.
  assign StallM = reset &&
                  (((state_q == S_IDLE) && req) ||
                   (state_q == S_BUSY) || (state_q == S_DRAIN));

  assign DoneM     = done_q;
  assign ReadDataM = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;

endmodule
`default_nettype wire

// File: tb/tb_vector_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_mem_sequencer
// Purpose  : Self-checking bench for vector_mem_sequencer. Directed steps
//            followed by randomized loads/stores, each checked cycle by cycle
//            against a transaction-level reference model (expected strobe
//            schedule, latency and a byte-addressed reference memory).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vector_mem_sequencer;

  localparam int I = 32;
  localparam int N = 8;
  localparam int R = 6;

  logic           clk = 1'b0;
  logic           reset;
  logic           MemWriteM, MemtoRegM, VectorM;
  logic [I-1:0]   AddressM;
  logic [R*N-1:0] WriteDataM;
  logic [R*N-1:0] ReadDataM;
  logic           StallM, DoneM;
  logic [I-1:0]   mem_addr;
  logic [N-1:0]   mem_wdata;
  logic           mem_we, mem_re;
  logic [N-1:0]   mem_rdata = '0;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_done_cyc = 0;

  // Environment memory (written by DUT strobes) and independent reference.
  logic [N-1:0] ram     [logic [31:0]];
  logic [N-1:0] ref_mem [logic [31:0]];
  logic [R*N-1:0] rd_model = '0;

  vector_mem_sequencer #(.I(I), .N(N), .R(R)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWriteM  (MemWriteM),
    .MemtoRegM  (MemtoRegM),
    .VectorM    (VectorM),
    .AddressM   (AddressM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .DoneM      (DoneM),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte-wide synchronous single-port memory.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] = mem_wdata;
    if (mem_re) mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : 8'h00;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [N-1:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  // Idle cycles with no request: nothing may move.
  task automatic idle(input int n);
    MemWriteM = 1'b0; MemtoRegM = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_stall", StallM, 1'b0);
      chk("idle_strobe", {mem_we, mem_re}, 2'b00);
      chk("idle_done", DoneM, 1'b0);
    end
  endtask

  // One complete access. Called in an IDLE cycle, away from the clock edge;
  // returns in the following IDLE cycle with the request removed.
  task automatic run_op(input string tag, input bit st, input bit ld, input bit vec,
                        input logic [31:0] addr, input logic [R*N-1:0] wd, input bit b2b);
    bit            is_store;
    int            lc, done_at;
    logic [R*N-1:0] exp_rd;
    logic [31:0]   ea;
    is_store   = st;
    lc         = vec ? R : 1;
    done_at    = is_store ? lc + 1 : lc + 2;
    MemWriteM  = st; MemtoRegM = ld; VectorM = vec;
    AddressM   = addr; WriteDataM = wd;

    if (is_store) begin
      exp_rd = rd_model;
      for (int k = 0; k < lc; k++) ref_mem[addr + 32'(k)] = wd[k*N +: N];
    end else begin
      exp_rd = '0;
      for (int k = 0; k < lc; k++) exp_rd[k*N +: N] = ref_rd(addr + 32'(k));
    end

    #1;
    chk({tag, "_c0_stall"}, StallM, 1'b1);
    chk({tag, "_c0_strobe"}, {mem_we, mem_re}, 2'b00);

    for (int c = 1; c <= done_at; c++) begin
      @(negedge clk);
      if (c <= lc) begin
        ea = addr + 32'(c - 1);
        chk({tag, "_we"}, mem_we, is_store);
        chk({tag, "_re"}, mem_re, !is_store);
        chk({tag, "_addr"}, mem_addr, ea);
        if (is_store) chk({tag, "_wdata"}, mem_wdata, wd[(c-1)*N +: N]);
        if (c == 1 && b2b) chk({tag, "_b2b_gap"}, 64'(cyc - last_done_cyc), 64'd2);
      end else begin
        chk({tag, "_strobe_off"}, {mem_we, mem_re}, 2'b00);
      end
      if (c == 1 && !is_store) chk({tag, "_rd_cleared"}, ReadDataM, '0);
      chk({tag, "_stall"}, StallM, c < done_at);
      chk({tag, "_done"}, DoneM, c == done_at);
    end
    last_done_cyc = cyc;
    chk({tag, "_rdata"}, ReadDataM, exp_rd);
    rd_model = exp_rd;

    MemWriteM = 1'b0; MemtoRegM = 1'b0;
    @(negedge clk);
    chk({tag, "_after_done"}, DoneM, 1'b0);
    chk({tag, "_after_stall"}, StallM, 1'b0);
  endtask

  initial begin
    logic [31:0]    ra;
    logic [R*N-1:0] rw;
    bit             rs, rl;

    reset = 1'b0;
    MemWriteM = 1'b1; MemtoRegM = 1'b0; VectorM = 1'b1;
    AddressM = 32'h0; WriteDataM = '0;

    // Reset: outputs cleared, StallM gated low even with a request present.
    @(negedge clk);
    @(negedge clk);
    chk("rst_stall", StallM, 1'b0);
    chk("rst_done", DoneM, 1'b0);
    chk("rst_strobe", {mem_we, mem_re}, 2'b00);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 8'h0);
    chk("rst_rdata", ReadDataM, '0);
    MemWriteM = 1'b0;
    reset = 1'b1;
    idle(2);

    // Vector store.
    run_op("vst", 1'b1, 1'b0, 1'b1, 32'h100, 48'h665544332211, 1'b0);

    // Vector load from preloaded memory.
    for (int k = 0; k < R; k++) begin
      ram[32'h200 + 32'(k)]     = 8'hA0 + 8'(k);
      ref_mem[32'h200 + 32'(k)] = 8'hA0 + 8'(k);
    end
    run_op("vld", 1'b0, 1'b1, 1'b1, 32'h200, '0, 1'b0);

    // Scalar store then scalar load.
    run_op("sst", 1'b1, 1'b0, 1'b0, 32'h010, 48'hDEADBEEF127E, 1'b0);
    run_op("sld", 1'b0, 1'b1, 1'b0, 32'h010, '0, 1'b0);

    // Wrap-around with simultaneous store/load request: store wins.
    run_op("wrap", 1'b1, 1'b1, 1'b1, 32'hFFFFFFFD, 48'hC6C5C4C3C2C1, 1'b0);
    idle(1);

    // Reset in the middle of a vector load (lane 3 on the strobes).
    MemtoRegM = 1'b1; VectorM = 1'b1; AddressM = 32'h200;
    for (int c = 1; c <= 4; c++) @(negedge clk);
    chk("rstmid_lane3_addr", mem_addr, 32'h203);
    chk("rstmid_lane3_re", mem_re, 1'b1);
    reset = 1'b0; MemtoRegM = 1'b0;
    @(negedge clk);
    chk("rstmid_re", mem_re, 1'b0);
    chk("rstmid_we", mem_we, 1'b0);
    chk("rstmid_stall", StallM, 1'b0);
    chk("rstmid_done", DoneM, 1'b0);
    chk("rstmid_rdata", ReadDataM, '0);
    rd_model = '0;
    reset = 1'b1;
    idle(2);
    run_op("recover", 1'b0, 1'b1, 1'b1, 32'h200, '0, 1'b0);

    // Back-to-back: load immediately followed by store.
    run_op("b2b_ld", 1'b0, 1'b1, 1'b1, 32'h100, '0, 1'b0);
    run_op("b2b_st", 1'b1, 1'b0, 1'b1, 32'h104, 48'h0F0E0D0C0B0A, 1'b1);

    // Randomized traffic in a small window so loads hit earlier stores.
    for (int t = 0; t < 24; t++) begin
      rs = 1'($urandom);
      rl = rs ? 1'($urandom) : 1'b1;
      ra = (t % 6 == 5) ? 32'hFFFFFFFF - 32'($urandom_range(0, 4))
                        : 32'h300 + 32'($urandom_range(0, 15));
      rw = {16'($urandom), $urandom};
      run_op("rnd", rs, rl, 1'($urandom), ra, rw, 1'b0);
      idle($urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
